bof_range_buffer: RTL
=====================

BOF_RANGE_BUFFER -- requirements
Module: bof_range_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of range entries (power of two, 2..32).
REQ-002 Parameter AW, default 32, address width.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 clr_i  in  1  synchronous clear of all entries (user buffer reset).
REQ-006 wr_en_i  in  1  one-cycle pulse: store range [addr_first_i, addr_last_i].
REQ-007 addr_first_i  in  AW  lowest byte address of the overflowed range.
REQ-008 addr_last_i  in  AW  highest byte address of the range (inclusive).
REQ-009 find_addr_i  in  AW  address under lookup (load effective address).
REQ-010 addr_in_range_o  out  1  find_addr_i lies inside a valid stored range.
REQ-011 hit_idx_o  out  $clog2(DEPTH)  index of the matching entry; 0 when no hit.
REQ-012 read_o  out  AW  addr_first of the most recently written entry.
REQ-013 read2_o  out  AW  addr_last of the most recently written entry.
REQ-014 count_o  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-015 wr_drop_o  out  1  registered one-cycle pulse: last write was rejected.
REQ-016 overwrite_o  out  1  registered one-cycle pulse: last write evicted the oldest valid entry.

Function
REQ-017 Storage: DEPTH entries, each {valid, first[AW], last[AW]}; write pointer wptr of $clog2(DEPTH) bits.
REQ-018 Accepted write: entry[wptr] <= {1, first, last}; wptr <= wptr+1 modulo DEPTH (wraps DEPTH-1 -> 0); visible from the next cycle.
REQ-019 Write rejected (no state change, wr_drop_o=1 next cycle) when addr_first_i > addr_last_i (unsigned).
REQ-020 Write rejected (wr_drop_o=1 next cycle) when an existing valid entry has identical first and last.
REQ-021 Full (count_o==DEPTH) and accepted write: oldest entry (at wptr) overwritten, count_o stays DEPTH, overwrite_o=1 next cycle.
REQ-022 count_o increments by 1 per accepted write below DEPTH; saturates at DEPTH.
REQ-023 Lookup combinational, zero latency: hit on entry i when valid[i] and first[i] <= find_addr_i <= last[i], unsigned, both bounds inclusive.
REQ-024 Multiple hits: hit_idx_o reports the lowest matching index; addr_in_range_o=1.
REQ-025 Lookup in the cycle of a write uses pre-write contents (no bypass).
REQ-026 read_o/read2_o reflect entry[wptr-1] (wrapping); both 0 when count_o==0.
REQ-027 clr_i: all valid bits, wptr, count_o cleared next cycle; stored addresses need not be cleared.
REQ-028 clr_i and wr_en_i same cycle: clear wins, write discarded, wr_drop_o and overwrite_o stay 0.
REQ-029 wr_en_i held multiple cycles: each high cycle is an independent write request.
REQ-030 wr_drop_o and overwrite_o are mutually exclusive and each high for exactly one cycle per causing write.

Reset
REQ-031 rst_ni low: all valid=0, wptr=0, count_o=0, wr_drop_o=0, overwrite_o=0, first/last=0, immediately and independent of clk_i.
REQ-032 Reset outputs: addr_in_range_o=0, hit_idx_o=0, read_o=0, read2_o=0.
REQ-033 Reset asserted mid-write: write lost; first post-reset cycle behaves as empty buffer.

Verification
REQ-034 Write [0x1000,0x1020]; next cycle find 0x0FFF/0x1000/0x1020/0x1021 -> addr_in_range_o 0/1/1/0, read_o=0x1000, read2_o=0x1020, count_o=1.
REQ-035 DEPTH=8: write 9 distinct ranges [0x100*k, 0x100*k+0x10], k=1..9 -> count_o=8, overwrite_o pulse after 9th, find 0x105 miss, find 0x905 hit idx 0.
REQ-036 Write [0x2000,0x1FFF] -> wr_drop_o=1 one cycle, count_o unchanged; rewrite existing [0x1000,0x1020] -> wr_drop_o=1, count_o unchanged.
REQ-037 Same cycle wr_en_i with find 0x3004 into new [0x3000,0x3010] -> hit=0 that cycle, hit=1 next cycle.
REQ-038 Three entries stored, clr_i with wr_en_i high -> next cycle count_o=0, all lookups miss, read_o=read2_o=0, no pulse outputs.
REQ-039 Overlapping entries idx2 [0x400,0x4FF] and idx5 [0x480,0x580], find 0x490 -> hit_idx_o=2; async rst_ni pulse mid-cycle -> outputs 0 before next edge.

Source files
------------

// File: rtl/bof_range_buffer.sv
// Bounds-overflow range buffer: small ring of [first,last] address ranges with
// a zero-latency, lowest-index-wins containment lookup.

// One stored entry's comparators: containment for lookup, exact match for duplicate rejection.
module bof_range_cmp #(
    parameter int AW = 32
) (
    input  logic          valid,
    input  logic [AW-1:0] first,
    input  logic [AW-1:0] last,
    input  logic [AW-1:0] find_addr,
    input  logic [AW-1:0] wr_first,
    input  logic [AW-1:0] wr_last,
    output logic          hit,
    output logic          dup
);
    assign hit = valid && (first <= find_addr) && (find_addr <= last);
    assign dup = valid && (first == wr_first) && (last == wr_last);
endmodule

module bof_range_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            addr_first_i,
    input  logic [AW-1:0]            addr_last_i,
    input  logic [AW-1:0]            find_addr_i,
    output logic                     addr_in_range_o,
    output logic [$clog2(DEPTH)-1:0] hit_idx_o,
    output logic [AW-1:0]            read_o,
    output logic [AW-1:0]            read2_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     wr_drop_o,
    output logic                     overwrite_o
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]         valid_q;
    logic [DEPTH-1:0][AW-1:0] first_q;
    logic [DEPTH-1:0][AW-1:0] last_q;
    logic [IW-1:0]            wptr_q;
    logic [IW-1:0]            rd_ptr;
    logic [CW-1:0]            count_q;
    logic                     drop_q;
    logic                     ovw_q;

    logic [DEPTH-1:0]         hit_vec;
    logic [DEPTH-1:0]         dup_vec;
    logic                     wr_req;
    logic                     reject;
    logic                     accept;
    logic                     full;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        bof_range_cmp #(.AW(AW)) u_cmp (
            .valid     (valid_q[g]),
            .first     (first_q[g]),
            .last      (last_q[g]),
            .find_addr (find_addr_i),
            .wr_first  (addr_first_i),
            .wr_last   (addr_last_i),
            .hit       (hit_vec[g]),
            .dup       (dup_vec[g])
        );
    end

    // Clear outranks the write, so a write in a clear cycle produces no pulse.
    assign wr_req = wr_en_i && !clr_i;
    assign reject = wr_req && ((addr_first_i > addr_last_i) || (|dup_vec));
    assign accept = wr_req && !reject;
    assign full   = (count_q == CW'(DEPTH));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            first_q <= '0;
            last_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            ovw_q   <= 1'b0;
        end else if (clr_i) begin
            valid_q <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            ovw_q   <= 1'b0;
        end else begin
            drop_q <= reject;
            ovw_q  <= accept && full;
            if (accept) begin
                valid_q[wptr_q] <= 1'b1;
                first_q[wptr_q] <= addr_first_i;
                last_q[wptr_q]  <= addr_last_i;
                wptr_q          <= wptr_q + IW'(1);
                if (!full) count_q <= count_q + CW'(1);
            end
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_idx_o = IW'(i);
        end
    end

    assign addr_in_range_o = |hit_vec;
    assign rd_ptr          = wptr_q - IW'(1);
    assign read_o          = (count_q != '0) ? first_q[rd_ptr] : '0;
    assign read2_o         = (count_q != '0) ? last_q[rd_ptr]  : '0;
    assign count_o         = count_q;
    assign wr_drop_o       = drop_q;
    assign overwrite_o     = ovw_q;
endmodule
